// File: rtl/matmul_sequencer.sv
// matmul_sequencer: loads A and B from a serial word stream into external sync-read RAMs,
// then walks the i/j/k read schedule through an internal MAC and streams C row-major.
// Optional build macro MATMUL_SAT_EN: saturating accumulation plus a sticky sat_flag output.
module matmul_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int MAX_DIM = 4,
    parameter int ADDR_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              a_we,
    output logic              b_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] a_raddr,
    output logic [ADDR_W-1:0] b_raddr,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_last,
    output logic              busy,
    output logic              err,
`ifdef MATMUL_SAT_EN
    output logic              sat_flag,
`endif
    output logic              done
);

    localparam int CNT_W = $clog2(MAX_DIM + 1);
    localparam logic [DATA_W-1:0] MAX_D = DATA_W'(MAX_DIM);
`ifdef MATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_WAIT_RES, S_ERR
    } state_t;

    function automatic logic dim_ok(input logic [DATA_W-1:0] d);
        return (d != '0) && (d <= MAX_D);
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(input logic [CNT_W-1:0] row,
                                                  input logic [CNT_W-1:0] col);
        return ADDR_W'(int'(row) * MAX_DIM + int'(col));
    endfunction

    function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] x,
                                                         input logic signed [ACC_W-1:0] y);
        return x + y;
    endfunction

`ifdef MATMUL_SAT_EN
    function automatic logic add_ovf(input logic signed [ACC_W-1:0] x,
                                     input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W-1:0] s;
        s = x + y;
        return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] x,
                                                        input logic signed [ACC_W-1:0] y);
        if (add_ovf(x, y))
            return x[ACC_W-1] ? ACC_MIN : ACC_MAX;
        return x + y;
    endfunction
`endif

    state_t r_state, w_next;

    logic [CNT_W-1:0] r_r1, r_c1, r_r2, r_c2;
    logic             r_hdr_bad;
    logic [1:0]       r_hcnt;
    logic [CNT_W-1:0] r_row, r_col;
    logic [CNT_W-1:0] r_i, r_j, r_k;
    logic             r_kdone, r_hold, r_done;
    logic             r_a_we, r_b_we;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic             r_mac_vld_p1, r_mac_first_p1, r_mac_last_p1;
    logic signed [ACC_W-1:0] r_acc;
`ifdef MATMUL_SAT_EN
    logic             r_sat_flag;
`endif

    logic             w_hs_in, w_hdr_fail;
    logic [CNT_W-1:0] w_ld_cols, w_ld_rows;
    logic             w_ld_col_end, w_ld_row_end, w_ld_end;
    logic             w_issue, w_k_end, w_last_res, w_mac_end;
    logic signed [2*DATA_W-1:0] w_prod_p1;
    logic signed [ACC_W-1:0]    w_prod_ext_p1, w_base_p1, w_acc_nxt_p1;

    assign w_hs_in      = in_valid && in_ready;
    assign w_hdr_fail   = r_hdr_bad || !dim_ok(in_data) || (r_c1 != r_r2);
    assign w_ld_cols    = (r_state == S_LOAD_A) ? r_c1 : r_c2;
    assign w_ld_rows    = (r_state == S_LOAD_A) ? r_r1 : r_r2;
    assign w_ld_col_end = (r_col == w_ld_cols - CNT_W'(1));
    assign w_ld_row_end = (r_row == w_ld_rows - CNT_W'(1));
    assign w_ld_end     = w_ld_col_end && w_ld_row_end;
    // r_hold skips one cycle after loading so the final B write lands before any read
    assign w_issue      = (r_state == S_COMPUTE) && !r_kdone && !r_hold;
    assign w_k_end      = (r_k == r_c1 - CNT_W'(1));
    assign w_last_res   = (r_i == r_r1 - CNT_W'(1)) && (r_j == r_c2 - CNT_W'(1));
    assign w_mac_end    = r_mac_vld_p1 && r_mac_last_p1;

    // p1: RAM data returns one cycle after issue; multiply and fold into the accumulator
    assign w_prod_p1     = $signed(a_rdata) * $signed(b_rdata);
    assign w_prod_ext_p1 = ACC_W'(w_prod_p1);
    assign w_base_p1     = r_mac_first_p1 ? '0 : r_acc;
`ifdef MATMUL_SAT_EN
    assign w_acc_nxt_p1  = sat_add(w_base_p1, w_prod_ext_p1);
`else
    assign w_acc_nxt_p1  = wrap_add(w_base_p1, w_prod_ext_p1);
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_hs_in) w_next = S_HDR;
            S_HDR:      if (w_hs_in && r_hcnt == 2'd2) w_next = w_hdr_fail ? S_ERR : S_LOAD_A;
            S_LOAD_A:   if (w_hs_in && w_ld_end) w_next = S_LOAD_B;
            S_LOAD_B:   if (w_hs_in && w_ld_end) w_next = S_COMPUTE;
            S_COMPUTE:  if (w_mac_end) w_next = S_WAIT_RES;
            S_WAIT_RES: if (res_ready) w_next = w_last_res ? S_IDLE : S_COMPUTE;
            S_ERR:      w_next = S_ERR;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        res_valid = 1'b0;
        res_last  = 1'b0;
        res_data  = '0;
        a_raddr   = '0;
        b_raddr   = '0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_HDR, S_LOAD_A, S_LOAD_B: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (w_issue) begin
                    a_raddr = mk_addr(r_i, r_k);
                    b_raddr = mk_addr(r_k, r_j);
                end
            end
            S_WAIT_RES: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                res_last  = w_last_res;
                res_data  = r_acc;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_r1 <= '0; r_c1 <= '0; r_r2 <= '0; r_c2 <= '0;
            r_hdr_bad <= 1'b0;
            r_hcnt    <= '0;
            r_row <= '0; r_col <= '0;
            r_i <= '0; r_j <= '0; r_k <= '0;
            r_kdone   <= 1'b0;
            r_hold    <= 1'b0;
            r_done    <= 1'b0;
            r_a_we    <= 1'b0;
            r_b_we    <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_mac_vld_p1   <= 1'b0;
            r_mac_first_p1 <= 1'b0;
            r_mac_last_p1  <= 1'b0;
            r_acc          <= '0;
`ifdef MATMUL_SAT_EN
            r_sat_flag     <= 1'b0;
`endif
        end else begin
            r_a_we <= 1'b0;
            r_b_we <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_hs_in) begin
                    r_r1      <= in_data[CNT_W-1:0];
                    r_hdr_bad <= ~dim_ok(in_data);
                    r_hcnt    <= '0;
                    r_row     <= '0;
                    r_col     <= '0;
`ifdef MATMUL_SAT_EN
                    r_sat_flag <= 1'b0;
`endif
                end
                S_HDR: if (w_hs_in) begin
                    r_hcnt    <= r_hcnt + 2'd1;
                    r_hdr_bad <= r_hdr_bad | ~dim_ok(in_data);
                    case (r_hcnt)
                        2'd0:    r_c1 <= in_data[CNT_W-1:0];
                        2'd1:    r_r2 <= in_data[CNT_W-1:0];
                        default: r_c2 <= in_data[CNT_W-1:0];
                    endcase
                end
                S_LOAD_A, S_LOAD_B: if (w_hs_in) begin
                    r_a_we    <= (r_state == S_LOAD_A);
                    r_b_we    <= (r_state == S_LOAD_B);
                    r_wr_addr <= mk_addr(r_row, r_col);
                    r_wr_data <= in_data;
                    if (w_ld_col_end) begin
                        r_col <= '0;
                        r_row <= w_ld_row_end ? '0 : r_row + CNT_W'(1);
                    end else begin
                        r_col <= r_col + CNT_W'(1);
                    end
                    if (r_state == S_LOAD_B && w_ld_end) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_kdone <= 1'b0;
                        r_hold  <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    r_hold <= 1'b0;
                    if (w_issue) begin
                        if (w_k_end)
                            r_kdone <= 1'b1;
                        else
                            r_k <= r_k + CNT_W'(1);
                    end
                end
                S_WAIT_RES: if (res_ready) begin
                    if (w_last_res) begin
                        r_done <= 1'b1;
                    end else begin
                        r_k     <= '0;
                        r_kdone <= 1'b0;
                        if (r_j == r_c2 - CNT_W'(1)) begin
                            r_j <= '0;
                            r_i <= r_i + CNT_W'(1);
                        end else begin
                            r_j <= r_j + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase

            // p0: issue cycle; tag what arrives from the RAMs on the next cycle
            r_mac_vld_p1   <= w_issue;
            r_mac_first_p1 <= w_issue && (r_k == '0);
            r_mac_last_p1  <= w_issue && w_k_end;
            if (r_mac_vld_p1) begin
                r_acc <= w_acc_nxt_p1;
`ifdef MATMUL_SAT_EN
                if (add_ovf(w_base_p1, w_prod_ext_p1))
                    r_sat_flag <= 1'b1;
`endif
            end
        end
    end

    assign a_we    = r_a_we;
    assign b_we    = r_b_we;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign done    = r_done;
`ifdef MATMUL_SAT_EN
    assign sat_flag = r_sat_flag;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Randomized self-checking bench for matmul_sequencer with behavioural RAMs and a
// plain-arithmetic matrix-product reference model.
`timescale 1ns/1ps
module tb_matmul_sequencer;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 16;
    localparam int MAX_DIM = 4;
    localparam int ADDR_W  = 4;
    localparam longint ACC_MAXV = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint ACC_MINV = -(longint'(1) << (ACC_W - 1));

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              a_we, b_we;
    logic [ADDR_W-1:0] wr_addr, a_raddr, b_raddr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] a_rdata = '0;
    logic [DATA_W-1:0] b_rdata = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [ACC_W-1:0]  res_data;
    logic              res_last, busy, err, done;
`ifdef MATMUL_SAT_EN
    logic              sat_flag;
`endif

    matmul_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a_we(a_we), .b_we(b_we), .wr_addr(wr_addr), .wr_data(wr_data),
        .a_raddr(a_raddr), .b_raddr(b_raddr), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .busy(busy), .err(err),
`ifdef MATMUL_SAT_EN
        .sat_flag(sat_flag),
`endif
        .done(done)
    );

    always #5 CLK = ~CLK;

    logic [DATA_W-1:0] mem_a [MAX_DIM*MAX_DIM];
    logic [DATA_W-1:0] mem_b [MAX_DIM*MAX_DIM];
    int n_awe = 0;
    int n_bwe = 0;

    always @(posedge CLK) begin
        if (a_we) begin mem_a[wr_addr] <= wr_data; n_awe <= n_awe + 1; end
        if (b_we) begin mem_b[wr_addr] <= wr_data; n_bwe <= n_bwe + 1; end
        a_rdata <= mem_a[a_raddr];
        b_rdata <= mem_b[b_raddr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int jr1, jc1, jr2, jc2;
    int ja [MAX_DIM*MAX_DIM];
    int jb [MAX_DIM*MAX_DIM];

    function automatic longint model_c(input int i, input int j, output bit clipped);
        longint acc = 0;
        clipped = 1'b0;
        for (int k = 0; k < jc1; k++) begin
            acc += longint'(ja[i*jc1+k]) * longint'(jb[k*jc2+j]);
`ifdef MATMUL_SAT_EN
            if (acc > ACC_MAXV) begin acc = ACC_MAXV; clipped = 1'b1; end
            else if (acc < ACC_MINV) begin acc = ACC_MINV; clipped = 1'b1; end
`endif
        end
`ifndef MATMUL_SAT_EN
        acc = acc & ((longint'(1) << ACC_W) - 1);
        if (acc > ACC_MAXV) acc -= (longint'(1) << ACC_W);
`endif
        return acc;
    endfunction

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic send_word(input int w, input bit gaps);
        bit ok = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) step();
        in_data  = w[DATA_W-1:0];
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge CLK);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!ok) check("in_accept_timeout", 0, 1);
    endtask

    task automatic send_all(input bit gaps);
        send_word(jr1, gaps); send_word(jc1, gaps);
        send_word(jr2, gaps); send_word(jc2, gaps);
        for (int i = 0; i < jr1*jc1; i++) send_word(ja[i], gaps);
        for (int i = 0; i < jr2*jc2; i++) send_word(jb[i], gaps);
    endtask

    task automatic recv_all(input bit gaps);
        int n = jr1 * jc2;
        int idx = 0;
        bit held = 1'b0;
        bit clip;
        longint hd = 0;
        longint exp;
        for (int cyc = 0; cyc < 3000 && idx < n; cyc++) begin
            res_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge CLK);
            if (held) begin
                check("res_valid_held", res_valid, 1);
                check("res_data_held", $signed(res_data), hd);
            end
            held = 1'b0;
            if (res_valid && res_ready) begin
                exp = model_c(idx / jc2, idx % jc2, clip);
                check("res_data", $signed(res_data), exp);
                check("res_last", res_last, idx == n - 1);
                check("in_ready_during_res", in_ready, 0);
                check("done_before_last", done, 0);
                idx++;
            end else if (res_valid) begin
                held = 1'b1;
                hd = $signed(res_data);
            end
            step();
        end
        res_ready = 1'b0;
        if (idx < n) begin
            check("res_timeout", idx, n);
        end else begin
            @(negedge CLK);
            check("done_pulse", done, 1);
            check("idle_in_ready", in_ready, 1);
            check("idle_busy", busy, 0);
            step();
            @(negedge CLK);
            check("done_one_cycle", done, 0);
            step();
        end
    endtask

    task automatic run_job(input bit gaps);
        bit clip, any_clip;
        longint dummy;
        any_clip = 1'b0;
        for (int e = 0; e < jr1*jc2; e++) begin
            dummy = model_c(e / jc2, e % jc2, clip);
            any_clip |= clip;
        end
        fork
            send_all(gaps);
            recv_all(gaps);
        join
        for (int i = 0; i < jr1; i++)
            for (int k = 0; k < jc1; k++)
                check("ram_a", $signed(mem_a[i*MAX_DIM+k]), ja[i*jc1+k]);
        for (int k = 0; k < jr2; k++)
            for (int j = 0; j < jc2; j++)
                check("ram_b", $signed(mem_b[k*MAX_DIM+j]), jb[k*jc2+j]);
`ifdef MATMUL_SAT_EN
        check("sat_flag", sat_flag, any_clip);
`else
        if (any_clip) check("model_clip_without_sat", 1, 0);
`endif
    endtask

    task automatic set_dims(input int r1, input int c1, input int r2, input int c2);
        jr1 = r1; jc1 = c1; jr2 = r2; jc2 = c2;
    endtask

    task automatic err_header(input int h0, input int h1, input int h2, input int h3);
        int awe0 = n_awe;
        int bwe0 = n_bwe;
        send_word(h0, 1'b0); send_word(h1, 1'b0);
        send_word(h2, 1'b0); send_word(h3, 1'b0);
        @(negedge CLK);
        check("err_set", err, 1);
        check("err_in_ready", in_ready, 0);
        check("err_busy", busy, 0);
        in_valid = 1'b1; in_data = 8'd1;
        repeat (6) step();
        in_valid = 1'b0;
        @(negedge CLK);
        check("err_sticky", err, 1);
        check("err_in_ready_hold", in_ready, 0);
        check("err_no_awe", n_awe - awe0, 0);
        check("err_no_bwe", n_bwe - bwe0, 0);
        step();
        do_reset();
        @(negedge CLK);
        check("err_cleared", err, 0);
        check("err_rst_in_ready", in_ready, 1);
        step();
    endtask

    initial begin
        bit seen;
        int hdr_bad [3][4] = '{'{0, 2, 2, 2}, '{2, 2, 2, 5}, '{5, 1, 1, 1}};

        repeat (3) step();
        @(negedge CLK);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_last", res_last, 0);
        check("rst_done", done, 0);
        check("rst_we", {a_we, b_we}, 0);
        check("rst_addrs", {wr_addr, a_raddr, b_raddr}, 0);
`ifdef MATMUL_SAT_EN
        check("rst_sat_flag", sat_flag, 0);
`endif
        step();
        RST = 1'b0;

        // 2x2 x 2x2 directed
        set_dims(2, 2, 2, 2);
        ja[0:3] = '{1, 2, 3, 4};
        jb[0:3] = '{5, 6, 7, 8};
        run_job(1'b0);

        // 2x3 x 3x1 with handshake gaps
        set_dims(2, 3, 3, 1);
        ja[0:5] = '{1, -1, 2, 0, 3, -2};
        jb[0:2] = '{4, 5, 6};
        run_job(1'b1);

        // 4x4 all -128: clips under saturation, wraps to 0 otherwise
        set_dims(4, 4, 4, 4);
        for (int i = 0; i < 16; i++) begin ja[i] = -128; jb[i] = -128; end
        run_job(1'b0);

        err_header(2, 3, 2, 2);
        for (int h = 0; h < 3; h++) err_header(hdr_bad[h][0], hdr_bad[h][1], hdr_bad[h][2], hdr_bad[h][3]);

        // reset in the middle of LOAD_B
        set_dims(2, 2, 2, 2);
        ja[0:3] = '{1, 1, 1, 1};
        jb[0:3] = '{2, 2, 2, 2};
        send_word(2, 1'b0); send_word(2, 1'b0); send_word(2, 1'b0); send_word(2, 1'b0);
        for (int i = 0; i < 4; i++) send_word(ja[i], 1'b0);
        send_word(jb[0], 1'b0); send_word(jb[1], 1'b0);
        @(negedge CLK);
        check("loadb_busy", busy, 1);
        step();
        do_reset();
        @(negedge CLK);
        check("rst_loadb_in_ready", in_ready, 1);
        check("rst_loadb_res_valid", res_valid, 0);
        check("rst_loadb_busy", busy, 0);
        step();

        // reset while holding a result in WAIT_RES
        send_all(1'b0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge CLK);
            seen = res_valid;
            step();
        end
        check("wait_res_reached", seen, 1);
        do_reset();
        @(negedge CLK);
        check("rst_wres_in_ready", in_ready, 1);
        check("rst_wres_res_valid", res_valid, 0);
        check("rst_wres_busy", busy, 0);
        step();

        // 1x1 x 1x1 after the aborts
        set_dims(1, 1, 1, 1);
        ja[0] = 3; jb[0] = -7;
        run_job(1'b0);

        for (int t = 0; t < 8; t++) begin
            set_dims($urandom_range(1, MAX_DIM), $urandom_range(1, MAX_DIM), 0, $urandom_range(1, MAX_DIM));
            jr2 = jc1;
            for (int i = 0; i < 16; i++) begin
                ja[i] = int'($urandom_range(0, 255)) - 128;
                jb[i] = int'($urandom_range(0, 255)) - 128;
            end
            run_job(t[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
